// File: rtl/core_exec_sequencer_pkg.sv
// Shared widths, sequencer state encodings and the decoded-control bundle
// for the RV32i multi-cycle execution sequencer.
package core_exec_sequencer_pkg;

  localparam int unsigned XLEN               = 32;
  localparam int unsigned DEF_MEM_ADDR_WIDTH = 32;
  localparam int unsigned CSR_OP_WIDTH       = 3;
  localparam int unsigned STATE_WIDTH        = 3;

  localparam logic [STATE_WIDTH-1:0] SEQ_FETCH  = 3'd0;
  localparam logic [STATE_WIDTH-1:0] SEQ_DECODE = 3'd1;
  localparam logic [STATE_WIDTH-1:0] SEQ_EXEC   = 3'd2;
  localparam logic [STATE_WIDTH-1:0] SEQ_MEM    = 3'd3;
  localparam logic [STATE_WIDTH-1:0] SEQ_WB     = 3'd4;
  localparam logic [STATE_WIDTH-1:0] SEQ_HALT   = 3'd5;

  // Decoder outputs for the instruction currently held in instr_o
  typedef struct packed {
    logic                    is_loadstore;
    logic                    is_store;
    logic                    is_branch;
    logic [CSR_OP_WIDTH-1:0] csr_op;
    logic                    rd_we;
    logic                    illegal;
  } dec_ctrl_t;

endpackage

// File: rtl/core_exec_sequencer_pc.sv
// Next-PC selection (sequential, absolute or PC-relative target) and the
// misaligned-target check applied before a committed PC update.
module core_exec_sequencer_pc
  import core_exec_sequencer_pkg::*;
#(
  parameter int unsigned AW = DEF_MEM_ADDR_WIDTH
) (
  input  logic [AW-1:0]   pc,
  input  logic            is_branch,
  input  logic            is_absolute,
  input  logic [XLEN-1:0] new_pc,
  output logic [AW-1:0]   next_pc_c,
  output logic            misaligned_c
);

  logic [XLEN-1:0] abs_target;

  // Absolute targets drop bit 0 (JALR semantics); arithmetic wraps at 2^AW
  always_comb begin
    abs_target = new_pc & ~XLEN'(1);
    if (!is_branch) begin
      next_pc_c = pc + AW'(4);
    end else if (is_absolute) begin
      next_pc_c = AW'(abs_target);
    end else begin
      next_pc_c = pc + AW'(new_pc);
    end
    misaligned_c = next_pc_c[1];
  end

endmodule

// File: rtl/core_exec_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer for the RV32i
// core: drives the imem/dmem handshakes and the commit strobes.
module core_exec_sequencer
  import core_exec_sequencer_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned     MEM_ADDR_WIDTH = DEF_MEM_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic                      imem_req_o,
  output logic [MEM_ADDR_WIDTH-1:0] imem_addr_o,
  input  logic                      imem_ack_i,
  input  logic [XLEN-1:0]           imem_rdata_i,
  output logic [XLEN-1:0]           instr_o,
  input  logic                      is_loadstore_i,
  input  logic                      is_store_i,
  input  logic                      is_branch_i,
  input  logic [CSR_OP_WIDTH-1:0]   csr_op_i,
  input  logic                      rd_we_i,
  input  logic                      illegal_i,
  input  logic                      is_absolute_i,
  input  logic [XLEN-1:0]           new_pc_i,
  output logic                      dmem_req_o,
  output logic                      dmem_we_o,
  input  logic                      dmem_ack_i,
  output logic [MEM_ADDR_WIDTH-1:0] pc_o,
  output logic                      rf_we_o,
  output logic                      csr_we_o,
  output logic [XLEN-1:0]           retired_o,
  output logic                      halted_o
);

  localparam int unsigned AW = MEM_ADDR_WIDTH;

  dec_ctrl_t              dec;
  logic [STATE_WIDTH-1:0] state_q;
  logic [STATE_WIDTH-1:0] state_d;
  logic [AW-1:0]          pc_d;
  logic [XLEN-1:0]        instr_d;
  logic [XLEN-1:0]        retired_d;
  logic                   imem_req_d;
  logic                   dmem_req_d;
  logic                   dmem_we_d;
  logic                   rf_we_d;
  logic                   csr_we_d;
  logic                   halted_d;
  logic                   commit_d;
  logic [AW-1:0]          next_pc;
  logic                   target_misaligned;

  assign dec = {is_loadstore_i, is_store_i, is_branch_i, csr_op_i, rd_we_i, illegal_i};
  assign imem_addr_o = pc_o;

  core_exec_sequencer_pc #(
    .AW (AW)
  ) u_pc (
    .pc           (pc_o),
    .is_branch    (dec.is_branch),
    .is_absolute  (is_absolute_i),
    .new_pc       (new_pc_i),
    .next_pc_c    (next_pc),
    .misaligned_c (target_misaligned)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEQ_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, architectural updates and next values of the registered outputs
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_o;
    instr_d   = instr_o;
    retired_d = retired_o;

    unique case (state_q)
      // An ack is only accepted once the request is actually visible
      SEQ_FETCH: begin
        if (imem_req_o && imem_ack_i) begin
          instr_d = imem_rdata_i;
          state_d = SEQ_DECODE;
        end
      end
      SEQ_DECODE: state_d = dec.illegal ? SEQ_HALT : SEQ_EXEC;
      SEQ_EXEC:   state_d = dec.is_loadstore ? SEQ_MEM : SEQ_WB;
      SEQ_MEM: begin
        if (dmem_ack_i) begin
          state_d = SEQ_WB;
        end
      end
      SEQ_WB: begin
        if (target_misaligned) begin
          state_d = SEQ_HALT;
        end else begin
          pc_d      = next_pc;
          retired_d = retired_o + XLEN'(1);
          state_d   = SEQ_FETCH;
        end
      end
      SEQ_HALT: state_d = SEQ_HALT;
      default:  state_d = SEQ_HALT;
    endcase

    // Outputs describe the state being entered; commit pulses are suppressed
    // up front when the upcoming WB will fault on a misaligned target
    imem_req_d = (state_d == SEQ_FETCH);
    dmem_req_d = (state_d == SEQ_MEM);
    dmem_we_d  = (state_d == SEQ_MEM) && dec.is_store;
    commit_d   = (state_d == SEQ_WB) && !target_misaligned;
    rf_we_d    = commit_d && dec.rd_we && !dec.is_store;
    csr_we_d   = commit_d && (dec.csr_op != '0);
    halted_d   = (state_d == SEQ_HALT);
  end

  // Registered outputs and architectural state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_o       <= AW'(RESET_PC);
      instr_o    <= '0;
      retired_o  <= '0;
      imem_req_o <= 1'b0;
      dmem_req_o <= 1'b0;
      dmem_we_o  <= 1'b0;
      rf_we_o    <= 1'b0;
      csr_we_o   <= 1'b0;
      halted_o   <= 1'b0;
    end else begin
      pc_o       <= pc_d;
      instr_o    <= instr_d;
      retired_o  <= retired_d;
      imem_req_o <= imem_req_d;
      dmem_req_o <= dmem_req_d;
      dmem_we_o  <= dmem_we_d;
      rf_we_o    <= rf_we_d;
      csr_we_o   <= csr_we_d;
      halted_o   <= halted_d;
    end
  end

endmodule
